// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        LD   = 2'd2,
        LINK = 2'd3
    } req_sel_e;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_payload_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard and outstanding-load counter; drives the decode hazard stall.
// Define RF_WB_BYPASS_EN to release the stall in the same cycle a load return is granted.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned LOAD_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs_i,
    input  reg_idx_t rt_i,
    input  logic     issue_i,
    input  reg_idx_t issue_rd_i,
    input  logic     ret_i,
    input  reg_idx_t ret_rd_i,
    output logic     stall_c_o,
    output logic     full_c_o
);

    localparam int unsigned CNT_W = $clog2(LOAD_DEPTH + 1);

    logic [NUM_REGS-1:1] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_eff;
    logic                issue_acc;

    // Register 0 is hard-wired not busy; a granted return may be bypassed.
    always_comb begin
        busy_eff = {busy_q, 1'b0};
`ifdef RF_WB_BYPASS_EN
        if (ret_i) begin
            busy_eff[ret_rd_i] = 1'b0;
        end
`endif
    end

    assign full_c_o  = (cnt_q == CNT_W'(LOAD_DEPTH));
    assign stall_c_o = rst & (busy_eff[rs_i] | busy_eff[rt_i] |
                              (issue_i & (busy_eff[issue_rd_i] | full_c_o)));
    assign issue_acc = issue_i & ~stall_c_o;

    // Clear is applied before set so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (ret_i && ret_rd_i != REG_ZERO) begin
            busy_d[ret_rd_i] = 1'b0;
        end
        if (issue_acc && issue_rd_i != REG_ZERO) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        if (issue_acc && !ret_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue_acc && ret_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single-port register-file writeback arbiter: load > link > ALU with ALU aging.
// Optional RF_WB_BYPASS_EN (in rf_scoreboard) releases load hazards in the return grant cycle.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned LOAD_DEPTH  = 2,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_req,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ack,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        link_req,
    input  logic [31:0] link_pc,
    output logic        link_ack,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        hazard_stall,
    output logic        ld_full,
    output logic        reg_write,
    output logic [4:0]  wreg,
    output logic [31:0] wdata
);

    localparam int unsigned AGE_W = 2;
    localparam logic [AGE_W-1:0] AGE_BOOST = AGE_W'(2);

    logic [AGE_W-1:0] age_q, age_d;
    req_sel_e         sel_c;
    wb_payload_t      wb_c, wb_q;
    logic             reg_write_q;

    // Grant selection; an ALU request aged twice overrides the fixed priority.
    always_comb begin
        sel_c = NONE;
        if (rst) begin
            if (alu_req && age_q == AGE_BOOST) begin
                sel_c = ALU;
            end else if (ld_valid) begin
                sel_c = LD;
            end else if (link_req) begin
                sel_c = LINK;
            end else if (alu_req) begin
                sel_c = ALU;
            end
        end
    end

    assign alu_ack  = (sel_c == ALU);
    assign ld_ready = (sel_c == LD);
    assign link_ack = (sel_c == LINK);

    always_comb begin
        wb_c = '0;
        unique case (sel_c)
            ALU:     wb_c = '{rd: alu_rd, data: alu_data};
            LD:      wb_c = '{rd: ld_rd, data: ld_data};
            LINK:    wb_c = '{rd: REG_LINK, data: link_pc + LINK_OFFSET};
            default: wb_c = '0;
        endcase
    end

    always_comb begin
        age_d = '0;
        if (alu_req && !alu_ack) begin
            age_d = (age_q == '1) ? age_q : age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q       <= '0;
            reg_write_q <= 1'b0;
            wb_q        <= '0;
        end else begin
            age_q       <= age_d;
            reg_write_q <= (sel_c != NONE) && (wb_c.rd != REG_ZERO);
            if (sel_c != NONE) begin
                wb_q <= wb_c;
            end
        end
    end

    assign reg_write = reg_write_q;
    assign wreg      = wb_q.rd;
    assign wdata     = wb_q.data;

    rf_scoreboard #(
        .LOAD_DEPTH (LOAD_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rs_i       (rs),
        .rt_i       (rt),
        .issue_i    (ld_issue),
        .issue_rd_i (ld_issue_rd),
        .ret_i      (ld_ready),
        .ret_rd_i   (ld_rd),
        .stall_c_o  (hazard_stall),
        .full_c_o   (ld_full)
    );

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: LOAD_DEPTH, 2, max outstanding loads tracked (1..7).
REQ-002 Parameter: LINK_OFFSET, 32'd8, offset added to link_pc for the return address.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 alu_req  in  1;  alu_rd  in  5;  alu_data  in  32  ALU writeback request.
REQ-006 alu_ack  out  1  ALU request granted this cycle.
REQ-007 ld_issue  in  1;  ld_issue_rd  in  5  load issued; destination becomes busy.
REQ-008 ld_valid  in  1;  ld_rd  in  5;  ld_data  in  32  load return request.
REQ-009 ld_ready  out  1  load return granted this cycle (valid/ready handshake).
REQ-010 link_req  in  1;  link_pc  in  32  jal/jalr link-write request.
REQ-011 link_ack  out  1  link request granted this cycle.
REQ-012 rs, rt  in  5 each  decode-stage source registers.
REQ-013 hazard_stall  out  1  decode must hold this cycle.
REQ-014 ld_full  out  1  outstanding-load count equals LOAD_DEPTH.
REQ-015 reg_write  out  1;  wreg  out  5;  wdata  out  32  registered register-file write port.

Function
REQ-016 At most one of alu_ack, ld_ready, link_ack shall be high per cycle; acks are combinational from current requests and state.
REQ-017 Priority: load > link > ALU, except when the ALU age counter equals 2, in which case ALU wins.
REQ-018 ALU age counter (2 bits, saturating): increments when alu_req && !alu_ack; clears on alu_ack or !alu_req.
REQ-019 Granted request appears on reg_write/wreg/wdata exactly one cycle after the grant; reg_write is low in cycles following no grant.
REQ-020 Link grant writes wreg=31, wdata=link_pc+LINK_OFFSET modulo 2^32.
REQ-021 Grants with destination 0 shall still be acked, but the next-cycle reg_write stays low.
REQ-022 Scoreboard busy[31:1]: set on accepted ld_issue for rd!=0; cleared on ld_ready for ld_rd; r0 is never busy.
REQ-023 Same-cycle set and clear of the same register: set wins.
REQ-024 Outstanding counter 0..LOAD_DEPTH: +1 on accepted ld_issue, -1 on ld_ready, unchanged when both occur; ld_issue is accepted only when !hazard_stall.
REQ-025 hazard_stall = busy[rs] | busy[rt] | (ld_issue & busy[ld_issue_rd]) | (ld_issue & ld_full).
REQ-026 ld_valid with an ld_rd that is not busy shall still be granted and written; the counter does not underflow (it holds at 0).

Reset
REQ-027 While rst=0 at a posedge: reg_write=0, wreg=0, wdata=0, busy cleared, counter=0, age=0.
REQ-028 While rst=0, alu_ack, ld_ready, link_ack and hazard_stall shall be 0; outstanding loads are discarded.

Configuration
REQ-029 Macro RF_WB_BYPASS_EN. When defined, a busy register whose load return is granted in the current cycle is treated as not busy for hazard_stall; the register file's write-through supplies the data.
REQ-030 When RF_WB_BYPASS_EN is undefined, hazard_stall holds until the cycle after busy clears.

Structure
REQ-031 The shared package holds the 5-bit register index type, the REG_LINK=31 and REG_ZERO=0 constants, and the requester-select enum (NONE, ALU, LD, LINK).
REQ-032 The scoreboard (busy vector plus outstanding counter) shall be one sub-module named rf_scoreboard; arbitration and the write-port register stay in the top level.

Verification
REQ-033 Single writeback: alu_req, rd=5, data=0x1234 -> alu_ack the same cycle; next cycle reg_write=1, wreg=5, wdata=0x1234.
REQ-034 Contention: alu_req and ld_valid held 3 cycles -> cycles 1-2 ld_ready; cycle 3 alu_ack (age=2).
REQ-035 Link: link_req, link_pc=0xBFC00100 -> next cycle wreg=31, wdata=0xBFC00108.
REQ-036 Load hazard: ld_issue rd=8, then rs=8 -> hazard_stall=1 until the ld_rd=8 return; the stall drops in the grant cycle with RF_WB_BYPASS_EN, one cycle later without it.
REQ-037 Full/reset: issue 2 loads -> ld_full=1, and a third ld_issue raises hazard_stall; assert rst=0 for 1 cycle -> ld_full=0, busy clear, reg_write=0.
